victim_buffer: RTL and testbench

Parametrised fully-associative victim buffer between the L1 data cache and the memory interface. It holds lines evicted from the L1 and returns a line to the L1 on a tag hit, removing that entry from the buffer. Entries carry valid and dirty state. Dirty lines displaced from the buffer are handed to memory through a valid/ready writeback port.

---
 rtl/victim_pkg.sv | 29 ++
 rtl/vc_slot_select.sv | 40 ++++
 rtl/victim_buffer.sv | 183 ++++++++++++++++++
 tb/tb_victim_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_pkg.sv
// victim_pkg: shared types and constants for the L1 victim buffer.
//   - default geometry constants used as parameter defaults
//   - slot-select case codes returned by vc_slot_select
//   - vc_entry_t: one buffer entry at the default geometry
//   - vc_wb_state_e: writeback FSM states
package victim_pkg;

    localparam int unsigned VC_ENTRIES_DEF = 4;
    localparam int unsigned LINE_WIDTH_DEF = 128;
    localparam int unsigned TAG_BITS_DEF   = 23;

    // Insert slot-selection cases, in priority order.
    localparam logic [1:0] SEL_MATCH  = 2'd1;  // valid entry with the same tag
    localparam logic [1:0] SEL_FREE   = 2'd2;  // lowest-index invalid entry
    localparam logic [1:0] SEL_VICTIM = 2'd3;  // entry at the replacement pointer

    typedef struct packed {
        logic                      valid;
        logic                      dirty;
        logic [TAG_BITS_DEF-1:0]   tag;
        logic [LINE_WIDTH_DEF-1:0] data;
    } vc_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        WB_PEND = 1'b1
    } vc_wb_state_e;

endpackage

// File: rtl/vc_slot_select.sv
// vc_slot_select: combinational insert-slot chooser for the victim buffer.
// Ports:
//   valid_i  per-entry valid bits
//   match_i  per-entry tag match against the insert tag (valid entries only)
//   ptr_i    round-robin replacement pointer
//   idx_o    chosen entry index
//   sel_o    which rule chose it (SEL_MATCH / SEL_FREE / SEL_VICTIM)
module vc_slot_select
    import victim_pkg::*;
#(
    parameter int unsigned N  = VC_ENTRIES_DEF,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [N-1:0]  match_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic [1:0]    sel_o
);

    always_comb begin
        idx_o = ptr_i;
        sel_o = SEL_VICTIM;
        // Scan downwards so the lowest free index is the last one kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o = IW'(i);
                sel_o = SEL_FREE;
            end
        end
        // A tag match outranks a free slot; at most one entry can match.
        for (int i = N - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                idx_o = IW'(i);
                sel_o = SEL_MATCH;
            end
        end
    end

endmodule

// File: rtl/victim_buffer.sv
// victim_buffer: fully-associative buffer of lines evicted from the L1.
// A lookup hit returns the line to the L1 and frees the entry. Dirty lines
// pushed out by round-robin replacement leave through the writeback port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lookup_req_i/lookup_tag_i     lookup request (one per cycle allowed)
//   lookup_rsp_o/hit/data/dirty   registered response, one cycle later
//   insert_valid_i/insert_ready_o evicted line offered by the L1
//   insert_tag_i/data/dirty       evicted line contents
//   wb_valid_o/wb_ready_i         dirty line handed to memory
//   wb_tag_o/wb_data_o            writeback line, stable while wb_valid_o
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both high; the sender holds its payload stable until then, and the
// ready side never depends combinationally on the valid side.
module victim_buffer
    import victim_pkg::*;
#(
    parameter int unsigned VC_ENTRIES = VC_ENTRIES_DEF,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned TAG_BITS   = TAG_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_req_i,
    input  logic [TAG_BITS-1:0]   lookup_tag_i,
    output logic                  lookup_rsp_o,
    output logic                  lookup_hit_o,
    output logic [LINE_WIDTH-1:0] lookup_data_o,
    output logic                  lookup_dirty_o,
    input  logic                  insert_valid_i,
    output logic                  insert_ready_o,
    input  logic [TAG_BITS-1:0]   insert_tag_i,
    input  logic [LINE_WIDTH-1:0] insert_data_i,
    input  logic                  insert_dirty_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [TAG_BITS-1:0]   wb_tag_o,
    output logic [LINE_WIDTH-1:0] wb_data_o
);

    localparam int unsigned IW = $clog2(VC_ENTRIES);

    logic [VC_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_BITS-1:0]   tag_q  [VC_ENTRIES];
    logic [LINE_WIDTH-1:0] line_q [VC_ENTRIES];
    logic [IW-1:0]         ptr_q, ptr_d;

    logic                  rsp_q, hit_q, rsp_dirty_q;
    logic [LINE_WIDTH-1:0] rsp_data_q;

    vc_wb_state_e          wb_state_q;
    logic                  wb_valid_q, ins_ready_q;
    logic [TAG_BITS-1:0]   wb_tag_q;
    logic [LINE_WIDTH-1:0] wb_data_q;

    logic [VC_ENTRIES-1:0] lk_match, ins_match;
    logic                  lk_hit;
    logic [IW-1:0]         lk_idx, sel_idx;
    logic [1:0]            sel_case;
    logic                  ins_accept, start_wb;

    // Tag compares against valid entries only, so stale tags never hit.
    always_comb begin
        lk_idx = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            lk_match[i]  = valid_q[i] && (tag_q[i] == lookup_tag_i);
            ins_match[i] = valid_q[i] && (tag_q[i] == insert_tag_i);
            if (lk_match[i]) lk_idx = IW'(i);
        end
        lk_hit = lookup_req_i && (|lk_match);
    end

    vc_slot_select #(
        .N  (VC_ENTRIES),
        .IW (IW)
    ) u_slot_select (
        .valid_i (valid_q),
        .match_i (ins_match),
        .ptr_i   (ptr_q),
        .idx_o   (sel_idx),
        .sel_o   (sel_case)
    );

    assign ins_accept = insert_valid_i && ins_ready_q;
    // A victim that the same-cycle lookup is already returning to the L1 is
    // not written back: the L1 owns that line now.
    assign start_wb   = ins_accept && (sel_case == SEL_VICTIM) && dirty_q[sel_idx]
                        && !(lk_hit && (lk_idx == sel_idx));

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        ptr_d   = ptr_q;
        if (lk_hit) valid_d[lk_idx] = 1'b0;
        // The insert is applied after the lookup clear so a slot that is both
        // hit and reused ends up holding the new line.
        if (ins_accept) begin
            valid_d[sel_idx] = 1'b1;
            dirty_d[sel_idx] = (sel_case == SEL_MATCH) ? (dirty_q[sel_idx] | insert_dirty_i)
                                                        : insert_dirty_i;
            if (sel_case == SEL_VICTIM) ptr_d = ptr_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            ptr_q   <= ptr_d;
        end
    end

    // Tag and line storage carry no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (ins_accept) begin
            tag_q[sel_idx]  <= insert_tag_i;
            line_q[sel_idx] <= insert_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q       <= 1'b0;
            hit_q       <= 1'b0;
            rsp_dirty_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_q       <= lookup_req_i;
            hit_q       <= lk_hit;
            rsp_dirty_q <= lk_hit && dirty_q[lk_idx];
            rsp_data_q  <= lk_hit ? line_q[lk_idx] : '0;
        end
    end

    // Writeback FSM. insert_ready_o is a register so wb_ready_i never
    // reaches it combinationally; it reads 0 in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_state_q  <= IDLE;
            wb_valid_q  <= 1'b0;
            ins_ready_q <= 1'b0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            case (wb_state_q)
                IDLE: begin
                    if (start_wb) begin
                        wb_state_q  <= WB_PEND;
                        wb_valid_q  <= 1'b1;
                        ins_ready_q <= 1'b0;
                        wb_tag_q    <= tag_q[sel_idx];
                        wb_data_q   <= line_q[sel_idx];
                    end else begin
                        wb_valid_q  <= 1'b0;
                        ins_ready_q <= 1'b1;
                    end
                end
                WB_PEND: begin
                    if (wb_ready_i) begin
                        wb_state_q  <= IDLE;
                        wb_valid_q  <= 1'b0;
                        ins_ready_q <= 1'b1;
                    end
                end
                default: wb_state_q <= IDLE;
            endcase
        end
    end

    assign lookup_rsp_o   = rsp_q;
    assign lookup_hit_o   = hit_q;
    assign lookup_data_o  = rsp_data_q;
    assign lookup_dirty_o = rsp_dirty_q;
    assign insert_ready_o = ins_ready_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_tag_o       = wb_tag_q;
    assign wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_victim_buffer.sv
// tb_victim_buffer: directed scenarios plus randomized traffic for
// victim_buffer, compared against an array model of the buffer contents.
module tb_victim_buffer;

    localparam int N  = 4;
    localparam int LW = 128;
    localparam int TW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_req_i;
    logic [TW-1:0] lookup_tag_i;
    logic          lookup_rsp_o, lookup_hit_o, lookup_dirty_o;
    logic [LW-1:0] lookup_data_o;
    logic          insert_valid_i, insert_ready_o, insert_dirty_i;
    logic [TW-1:0] insert_tag_i;
    logic [LW-1:0] insert_data_i;
    logic          wb_valid_o, wb_ready_i;
    logic [TW-1:0] wb_tag_o;
    logic [LW-1:0] wb_data_o;

    victim_buffer #(
        .VC_ENTRIES (N),
        .LINE_WIDTH (LW),
        .TAG_BITS   (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_req_i   (lookup_req_i),
        .lookup_tag_i   (lookup_tag_i),
        .lookup_rsp_o   (lookup_rsp_o),
        .lookup_hit_o   (lookup_hit_o),
        .lookup_data_o  (lookup_data_o),
        .lookup_dirty_o (lookup_dirty_o),
        .insert_valid_i (insert_valid_i),
        .insert_ready_o (insert_ready_o),
        .insert_tag_i   (insert_tag_i),
        .insert_data_i  (insert_data_i),
        .insert_dirty_i (insert_dirty_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_tag_o       (wb_tag_o),
        .wb_data_o      (wb_data_o)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer as a plain array of lines.
    logic          m_valid [N];
    logic          m_dirty [N];
    logic [TW-1:0] m_tag   [N];
    logic [LW-1:0] m_data  [N];
    int            m_ptr;
    logic          m_pend, m_ready;
    logic [TW+LW-1:0] exp_q[$];       // writebacks expected, oldest first
    logic [LW+2:0] rsp_exp;          // {rsp, hit, dirty, data}

    wire [LW+2:0] rsp_act = {lookup_rsp_o, lookup_hit_o, lookup_dirty_o, lookup_data_o};
    wire [1:0]    wb_act  = {wb_valid_o, insert_ready_o};
    wire [1:0]    wb_exp  = {m_pend, m_ready};

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_ptr   = 0;
        m_pend  = 1'b0;
        m_ready = 1'b0;
        rsp_exp = '0;
        exp_q.delete();
    endtask

    // Drives one cycle of inputs, advances the model, clocks, and returns
    // #1 after the edge. Writeback handshakes are checked against exp_q.
    task automatic do_cycle(input logic req, input logic [TW-1:0] ltag,
                            input logic ins, input logic [TW-1:0] itag,
                            input logic [LW-1:0] idata, input logic idirty,
                            input logic wbr);
        int h, s, kind;
        logic npend, hit;
        logic [TW+LW-1:0] exp_wb;
        lookup_req_i   = req;
        lookup_tag_i   = ltag;
        insert_valid_i = ins;
        insert_tag_i   = itag;
        insert_data_i  = idata;
        insert_dirty_i = idirty;
        wb_ready_i     = wbr;
        #1;
        if (wb_valid_o && wbr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_handshake: got tag %h with none expected", wb_tag_o);
            end else begin
                exp_wb = exp_q.pop_front();
                if ({wb_tag_o, wb_data_o} !== exp_wb)
                    $display("FAIL wb_handshake: got %h expected %h", {wb_tag_o, wb_data_o}, exp_wb);
                else
                    n_pass++;
            end
        end
        h = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == ltag) h = i;
        hit     = req && (h >= 0);
        rsp_exp = {req, hit, hit ? m_dirty[h] : 1'b0, hit ? m_data[h] : {LW{1'b0}}};
        s = -1;
        kind = 0;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == itag) begin s = i; kind = 1; end
        if (s < 0)
            for (int i = N - 1; i >= 0; i--)
                if (!m_valid[i]) begin s = i; kind = 2; end
        if (s < 0) begin s = m_ptr; kind = 3; end
        npend = m_pend && !wbr;
        if (ins && m_ready) begin
            if (kind == 3 && m_dirty[s] && !(hit && h == s)) begin
                exp_q.push_back({m_tag[s], m_data[s]});
                npend = 1'b1;
            end
            if (hit) m_valid[h] = 1'b0;
            m_dirty[s] = (kind == 1) ? (m_dirty[s] | idirty) : idirty;
            m_valid[s] = 1'b1;
            m_tag[s]   = itag;
            m_data[s]  = idata;
            if (kind == 3) m_ptr = (m_ptr + 1) % N;
        end else if (hit) begin
            m_valid[h] = 1'b0;
        end
        m_pend  = npend;
        m_ready = !npend;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        lookup_req_i   = 1'b0;
        lookup_tag_i   = '0;
        insert_valid_i = 1'b0;
        insert_tag_i   = '0;
        insert_data_i  = '0;
        insert_dirty_i = 1'b0;
        wb_ready_i     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({rsp_act, wb_act} !== '0)
            $display("FAIL reset_ctrl: got %h expected 0", {rsp_act, wb_act});
        else n_pass++;
        n_checks++;
        if ({wb_tag_o, wb_data_o} !== '0)
            $display("FAIL reset_wb_regs: got %h expected 0", {wb_tag_o, wb_data_o});
        else n_pass++;
        idle();
        n_checks++;
        if (insert_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", insert_ready_o);
        else n_pass++;
        do_cycle(1'b1, TW'(0), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({lookup_rsp_o, lookup_hit_o} !== 2'b10)
            $display("FAIL reset_zero_tag: got %b expected 10", {lookup_rsp_o, lookup_hit_o});
        else n_pass++;
    endtask

    task automatic test_clean_replace();
        apply_reset();
        idle();
        for (int t = 'h10; t <= 'h15; t++) begin
            do_cycle(1'b0, '0, 1'b1, TW'(t), rand_line(), 1'b0, 1'b0);
            n_checks++;
            if (wb_act !== 2'b01) $display("FAIL clean_no_wb: got %b expected 01", wb_act);
            else n_pass++;
        end
        // 0x14 replaced slot 0, 0x15 replaced slot 1 (pointer had moved to 1).
        do_cycle(1'b1, TW'('h11), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b0 || rsp_act !== rsp_exp)
            $display("FAIL clean_ptr_victim: got %h expected %h", rsp_act, rsp_exp);
        else n_pass++;
        do_cycle(1'b1, TW'('h10), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b0) $display("FAIL clean_slot0_gone: got %b expected 0", lookup_hit_o);
        else n_pass++;
        do_cycle(1'b1, TW'('h12), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b1 || rsp_act !== rsp_exp)
            $display("FAIL clean_survivor: got %h expected %h", rsp_act, rsp_exp);
        else n_pass++;
    endtask

    task automatic test_dirty_writeback();
        logic [LW-1:0] d0;
        apply_reset();
        idle();
        d0 = rand_line();
        do_cycle(1'b0, '0, 1'b1, TW'('h20), d0, 1'b1, 1'b0);
        for (int t = 'h21; t <= 'h24; t++)
            do_cycle(1'b0, '0, 1'b1, TW'(t), rand_line(), 1'b1, 1'b0);
        n_checks++;
        if (wb_act !== 2'b10 || wb_tag_o !== TW'('h20) || wb_data_o !== d0)
            $display("FAIL dirty_wb_start: got %b/%h expected 10/000020", wb_act, wb_tag_o);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            do_cycle(1'b0, '0, 1'b1, TW'('h25), rand_line(), 1'b1, 1'b0);
            n_checks++;
            if (wb_tag_o !== TW'('h20) || insert_ready_o !== 1'b0)
                $display("FAIL dirty_wb_hold: got %h/%b expected 000020/0", wb_tag_o, insert_ready_o);
            else n_pass++;
        end
        do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (wb_act !== 2'b01) $display("FAIL dirty_wb_release: got %b expected 01", wb_act);
        else n_pass++;
        do_cycle(1'b1, TW'('h25), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b0) $display("FAIL dirty_blocked_insert: got %b expected 0", lookup_hit_o);
        else n_pass++;
        do_cycle(1'b1, TW'('h21), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_dirty_o !== 1'b1 || rsp_act !== rsp_exp)
            $display("FAIL dirty_hit: got %h expected %h", rsp_act, rsp_exp);
        else n_pass++;
    endtask

    task automatic test_hit_remove();
        logic [LW-1:0] a5;
        a5 = {16{8'hA5}};
        apply_reset();
        idle();
        do_cycle(1'b0, '0, 1'b1, TW'('h30), a5, 1'b0, 1'b0);
        do_cycle(1'b1, TW'('h30), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b1 || lookup_data_o !== a5)
            $display("FAIL hit_data: got %b/%h expected 1/%h", lookup_hit_o, lookup_data_o, a5);
        else n_pass++;
        do_cycle(1'b1, TW'('h30), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (rsp_act !== {3'b100, {LW{1'b0}}})
            $display("FAIL hit_removed: got %h expected %h", rsp_act, {3'b100, {LW{1'b0}}});
        else n_pass++;
    endtask

    task automatic test_merge();
        logic [LW-1:0] d1;
        apply_reset();
        idle();
        d1 = rand_line();
        do_cycle(1'b0, '0, 1'b1, TW'('h40), rand_line(), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h40), d1, 1'b1, 1'b0);
        do_cycle(1'b1, TW'('h40), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({lookup_hit_o, lookup_dirty_o} !== 2'b11 || lookup_data_o !== d1 || wb_valid_o !== 1'b0)
            $display("FAIL merge_hit: got %b%b%b expected 110", lookup_hit_o, lookup_dirty_o, wb_valid_o);
        else n_pass++;
        do_cycle(1'b1, TW'('h40), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b0) $display("FAIL merge_single_entry: got %b expected 0", lookup_hit_o);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] d52, d60;
        apply_reset();
        idle();
        d52 = rand_line();
        d60 = rand_line();
        do_cycle(1'b0, '0, 1'b1, TW'('h5A), rand_line(), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h5B), rand_line(), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h52), d52, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h53), rand_line(), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h50), rand_line(), 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, TW'('h51), rand_line(), 1'b0, 1'b0);
        // Pointer now at slot 2, which holds dirty 0x52.
        do_cycle(1'b1, TW'('h52), 1'b1, TW'('h60), d60, 1'b0, 1'b0);
        n_checks++;
        if ({lookup_hit_o, lookup_dirty_o} !== 2'b11 || lookup_data_o !== d52)
            $display("FAIL simul_hit: got %b%b/%h expected 11/%h", lookup_hit_o, lookup_dirty_o, lookup_data_o, d52);
        else n_pass++;
        n_checks++;
        if (wb_act !== 2'b01) $display("FAIL simul_no_wb: got %b expected 01", wb_act);
        else n_pass++;
        do_cycle(1'b1, TW'('h60), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b1 || lookup_data_o !== d60)
            $display("FAIL simul_new_line: got %b/%h expected 1/%h", lookup_hit_o, lookup_data_o, d60);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] tags [4];
        logic          hits [4];
        tags = '{TW'('h81), TW'('h80), TW'('h81), TW'('h82)};
        hits = '{1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        idle();
        for (int t = 'h80; t <= 'h82; t++)
            do_cycle(1'b0, '0, 1'b1, TW'(t), rand_line(), t[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_cycle(1'b1, tags[k], 1'b0, '0, '0, 1'b0, 1'b0);
            n_checks++;
            if (lookup_hit_o !== hits[k] || rsp_act !== rsp_exp)
                $display("FAIL b2b_lookup%0d: got %h expected %h", k, rsp_act, rsp_exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_wb();
        apply_reset();
        idle();
        for (int t = 'h90; t <= 'h94; t++)
            do_cycle(1'b0, '0, 1'b1, TW'(t), rand_line(), 1'b1, 1'b0);
        n_checks++;
        if (wb_valid_o !== 1'b1) $display("FAIL midwb_pending: got %b expected 1", wb_valid_o);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (wb_act !== 2'b00) $display("FAIL midwb_reset: got %b expected 00", wb_act);
        else n_pass++;
        idle();
        do_cycle(1'b1, TW'('h91), 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (lookup_hit_o !== 1'b0) $display("FAIL midwb_cleared: got %b expected 0", lookup_hit_o);
        else n_pass++;
    endtask

    task automatic test_random();
        int guard;
        apply_reset();
        idle();
        for (int c = 0; c < 500; c++) begin
            do_cycle(1'($urandom_range(0, 1)), TW'('h70 + $urandom_range(0, 7)),
                     1'($urandom_range(0, 2) != 0), TW'('h70 + $urandom_range(0, 7)),
                     rand_line(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            n_checks++;
            if (rsp_act !== rsp_exp || wb_act !== wb_exp)
                $display("FAIL rand_cycle%0d: got %h/%b expected %h/%b", c, rsp_act, wb_act, rsp_exp, wb_exp);
            else n_pass++;
            if (m_pend && exp_q.size() > 0) begin
                n_checks++;
                if ({wb_tag_o, wb_data_o} !== exp_q[0])
                    $display("FAIL rand_wb_line%0d: got %h expected %h", c, {wb_tag_o, wb_data_o}, exp_q[0]);
                else n_pass++;
            end
        end
        guard = 0;
        while (m_pend && guard < 50) begin
            do_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
            guard++;
        end
        n_checks++;
        if (wb_valid_o !== 1'b0 || exp_q.size() != 0)
            $display("FAIL rand_drain: got wb_valid %b queue %0d expected 0 0", wb_valid_o, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_replace();
        test_dirty_writeback();
        test_hit_remove();
        test_merge();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
